arr_stim: RTL and testbench

- Stimulus source for the `arr` equality checkers instantiated inside `duv`; it is the driving end of their `sig0`/`sig1` compare interface.
- On a start pulse it issues a programmed number of pseudo-random vectors.
- Each vector drives identical values on both outputs, except an optional single deliberately corrupted vector.
- Clocked from `sim_ctrl`; used to exercise checker pass and fail paths without Python/VPI writes.

---
 rtl/arr_stim.sv | 175 +++++++++++++++++
 tb/tb_arr_stim.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arr_stim.sv
// -----------------------------------------------------------------------------
// arr_stim
// Stimulus source for the `arr` equality checkers inside `duv`. On a start
// pulse it issues a programmed number of pseudo-random vectors, driving the
// same value on sig0 and sig1 so a checker sees matching inputs. When built
// with the macro ARR_STIM_INJECT_EN, one selected vector can be issued with
// bit 0 of sig1 inverted to exercise the checker's fail path.
//
// Parameters:
//   LENGTH  width of sig0/sig1 (1..255)
//   CNT_W   width of the vector count, inject index and sent counter
//
// Ports:
//   stim_clk_ip     clock
//   stim_rst_ip     asynchronous active-high reset
//   stim_start_ip   start request, only honoured in IDLE
//   stim_hold_ip    stall; no vector is issued while high
//   stim_count_ip   number of vectors to issue (latched on start)
//   stim_seed_ip    LFSR seed (latched on start, 0 replaced by 1)
//   stim_inject_ip  1-based index of vector to corrupt, 0 = none
//                   (used only when ARR_STIM_INJECT_EN is defined)
//   stim_sig0_op    reference vector
//   stim_sig1_op    compare vector
//   stim_valid_op   a vector was issued this cycle
//   stim_busy_op    sequence in progress
//   stim_done_op    one-cycle completion pulse
//   stim_sent_op    vectors issued since the last start
//
// Handshake: stim_valid_op is a qualifier only; there is no ready. A vector
// is presented for exactly the one cycle in which valid is high, and hold
// is the only back-pressure (a held cycle issues nothing and loses nothing).
// -----------------------------------------------------------------------------
module arr_stim #(
   parameter int LENGTH = 8,
   parameter int CNT_W  = 16
) (
   input  logic              stim_clk_ip,
   input  logic              stim_rst_ip,
   input  logic              stim_start_ip,
   input  logic              stim_hold_ip,
   input  logic [CNT_W-1:0]  stim_count_ip,
   input  logic [31:0]       stim_seed_ip,
   input  logic [CNT_W-1:0]  stim_inject_ip,
   output logic [LENGTH-1:0] stim_sig0_op,
   output logic [LENGTH-1:0] stim_sig1_op,
   output logic              stim_valid_op,
   output logic              stim_busy_op,
   output logic              stim_done_op,
   output logic [CNT_W-1:0]  stim_sent_op
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   logic [1:0]        r_state;
   logic [31:0]       r_lfsr;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  r_sent;
   logic [LENGTH-1:0] r_sig0;
   logic [LENGTH-1:0] r_sig1;
   logic              r_valid;
   logic              r_busy;
   logic              r_done;

   logic [31:0]       w_lfsr_next;
   logic [31:0]       w_seed;
   logic [LENGTH-1:0] w_vector;
   logic [LENGTH-1:0] w_sig1;
   logic [CNT_W-1:0]  w_sent_inc;
   logic              w_last;

   // Galois right-shift LFSR step.
   assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
   // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
   assign w_seed      = (stim_seed_ip == 32'h0) ? 32'h1 : stim_seed_ip;
   assign w_sent_inc  = r_sent + {{(CNT_W-1){1'b0}}, 1'b1};
   assign w_last      = (w_sent_inc == r_count);

   // The LFSR is repeated across the vector width so every bit of a wide
   // vector toggles; bit 0 of the vector is always LFSR bit 0.
   always_comb begin
      w_vector = '0;
      for (int i = 0; i < LENGTH; i++) begin
         w_vector[i] = r_lfsr[i % 32];
      end
   end

`ifdef ARR_STIM_INJECT_EN
   logic [CNT_W-1:0] r_inject;
   logic             w_corrupt;

   // Index 0 never matches a 1-based position, and an index beyond the
   // count is never reached, so both mean "no corruption".
   assign w_corrupt = (r_inject != '0) && (w_sent_inc == r_inject);

   always_comb begin
      w_sig1    = w_vector;
      w_sig1[0] = w_vector[0] ^ w_corrupt;
   end

   always_ff @(posedge stim_clk_ip or posedge stim_rst_ip) begin
      if (stim_rst_ip) begin
         r_inject <= '0;
      end else if ((r_state == ST_IDLE) && stim_start_ip) begin
         r_inject <= stim_inject_ip;
      end
   end
`else
   logic w_unused_inject;

   // Port kept for a stable interface; no corruption logic exists here.
   assign w_unused_inject = ^stim_inject_ip;
   assign w_sig1          = w_vector;
`endif

   always_ff @(posedge stim_clk_ip or posedge stim_rst_ip) begin
      if (stim_rst_ip) begin
         r_state <= ST_IDLE;
         r_lfsr  <= '0;
         r_count <= '0;
         r_sent  <= '0;
         r_sig0  <= '0;
         r_sig1  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (stim_start_ip) begin
                  r_count <= stim_count_ip;
                  r_lfsr  <= w_seed;
                  r_sent  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= (stim_count_ip == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (!stim_hold_ip) begin
                  r_sig0  <= w_vector;
                  r_sig1  <= w_sig1;
                  r_valid <= 1'b1;
                  r_lfsr  <= w_lfsr_next;
                  r_sent  <= w_sent_inc;
                  if (w_last) begin
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign stim_sig0_op  = r_sig0;
   assign stim_sig1_op  = r_sig1;
   assign stim_valid_op = r_valid;
   assign stim_busy_op  = r_busy;
   assign stim_done_op  = r_done;
   assign stim_sent_op  = r_sent;

endmodule

// File: tb/tb_arr_stim.sv
// -----------------------------------------------------------------------------
// tb_arr_stim
// Directed bench for arr_stim. A behavioural model turns every accepted start
// into a queue of expected vectors (plain LFSR arithmetic) and a compare
// process checks all outputs after every clock edge. Directed tests also pin
// the model with hand-computed vectors and edge timings.
// -----------------------------------------------------------------------------
module tb_arr_stim;
   localparam int LENGTH = 8;
   localparam int CNT_W  = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              hold = 1'b0;
   logic [CNT_W-1:0]  count = '0;
   logic [31:0]       seed = '0;
   logic [CNT_W-1:0]  inject = '0;
   logic [LENGTH-1:0] sig0;
   logic [LENGTH-1:0] sig1;
   logic              valid;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  sent;

   arr_stim #(.LENGTH(LENGTH), .CNT_W(CNT_W)) dut (
      .stim_clk_ip    (clk),
      .stim_rst_ip    (rst),
      .stim_start_ip  (start),
      .stim_hold_ip   (hold),
      .stim_count_ip  (count),
      .stim_seed_ip   (seed),
      .stim_inject_ip (inject),
      .stim_sig0_op   (sig0),
      .stim_sig1_op   (sig1),
      .stim_valid_op  (valid),
      .stim_busy_op   (busy),
      .stim_done_op   (done),
      .stim_sent_op   (sent)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;

   // model state
   logic [LENGTH-1:0] exp_q[$];
   bit                m_busy = 0;
   bit                m_finish = 0;
   int                m_inject = 0;
   int                m_sent = 0;
   logic [LENGTH-1:0] m_sig0 = '0;
   logic [LENGTH-1:0] m_sig1 = '0;
   bit                m_valid = 0;
   bit                m_done = 0;

   // observation logs for the directed tests
   logic [LENGTH-1:0] seen0_q[$];
   logic [LENGTH-1:0] seen1_q[$];
   int                valid_edges[$];
   int                done_edges[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] lfsr_adv(input logic [31:0] l);
      return (l >> 1) ^ ((l & 32'h1) != 0 ? 32'h8020_0003 : 32'h0);
   endfunction

   function automatic logic [LENGTH-1:0] vec_of(input logic [31:0] l);
      logic [LENGTH-1:0] v;
      for (int i = 0; i < LENGTH; i++) v[i] = l[i % 32];
      return v;
   endfunction

   // Expected outputs after an edge, from the inputs seen at that edge.
   task automatic model_step();
      logic [31:0] l;
      logic [LENGTH-1:0] v;
      m_valid = 0;
      m_done  = 0;
      if (rst) begin
         exp_q.delete();
         m_busy = 0; m_finish = 0; m_inject = 0; m_sent = 0;
         m_sig0 = '0; m_sig1 = '0;
      end else if (m_finish) begin
         m_done = 1; m_busy = 0; m_finish = 0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy = 1;
            m_sent = 0;
            m_inject = int'(inject);
            l = (seed == 0) ? 32'h1 : seed;
            exp_q.delete();
            for (int k = 0; k < int'(count); k++) begin
               exp_q.push_back(vec_of(l));
               l = lfsr_adv(l);
            end
            if (count == 0) m_finish = 1;
         end
      end else if (exp_q.size() > 0 && !hold) begin
         v = exp_q.pop_front();
         m_sent++;
         m_sig0 = v;
         m_sig1 = v;
`ifdef ARR_STIM_INJECT_EN
         if (m_inject != 0 && m_sent == m_inject) m_sig1[0] = ~v[0];
`endif
         m_valid = 1;
         if (exp_q.size() == 0) m_finish = 1;
      end
   endtask

   // compare process: every edge, outputs checked 1 time unit later
   initial begin
      forever begin
         @(posedge clk);
         edge_cnt++;
         model_step();
         #1;
         check("valid", 64'(valid), 64'(m_valid));
         check("done",  64'(done),  64'(m_done));
         check("busy",  64'(busy),  64'(m_busy));
         check("sent",  64'(sent),  64'(m_sent));
         check("sig0",  64'(sig0),  64'(m_sig0));
         check("sig1",  64'(sig1),  64'(m_sig1));
         if (valid) begin
            seen0_q.push_back(sig0);
            seen1_q.push_back(sig1);
            valid_edges.push_back(edge_cnt);
         end
         if (done) done_edges.push_back(edge_cnt);
      end
   end

   task automatic clear_logs();
      seen0_q.delete(); seen1_q.delete();
      valid_edges.delete(); done_edges.delete();
   endtask

   // Returns the index of the edge that sampled start.
   task automatic do_start(input logic [31:0] s, input int c, input int inj, output int n);
      @(negedge clk);
      seed = s; count = CNT_W'(c); inject = CNT_W'(inj); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = edge_cnt;
   endtask

   task automatic check_vec(input string name, input logic [LENGTH-1:0] q[$], input int i,
                            input logic [LENGTH-1:0] req);
      logic [LENGTH-1:0] got;
      got = (i < q.size()) ? q[i] : 'x;
      check(name, 64'(got), 64'(req));
   endtask

   task automatic check_edge(input string name, input int q[$], input int i, input int req);
      int got;
      got = (i < q.size()) ? q[i] : -1;
      check(name, 64'(got), 64'(req));
   endtask

   initial begin
      int n;
      logic [LENGTH-1:0] basic[4];
      basic[0] = 8'h01; basic[1] = 8'h03; basic[2] = 8'h02; basic[3] = 8'h01;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_sig0", 64'(sig0), 64'h0);
      check("rst_valid", 64'(valid), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // basic sequence, seed 1, count 4
      clear_logs();
      do_start(32'h1, 4, 0, n);
      check("basic_busy", 64'(busy), 64'h1);
      repeat (8) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check_vec("basic_sig0", seen0_q, i, basic[i]);
         check_vec("basic_sig1", seen1_q, i, basic[i]);
         check_edge("basic_valid_edge", valid_edges, i, n + 1 + i);
      end
      check("basic_nvalid", 64'(valid_edges.size()), 64'd4);
      check_edge("basic_done_edge", done_edges, 0, n + 5);
      check("basic_sent", 64'(sent), 64'd4);
      check("basic_busy_end", 64'(busy), 64'h0);
      check("basic_sig_hold", 64'(sig0), 64'h01);

      // zero seed behaves as seed 1
      clear_logs();
      do_start(32'h0, 3, 0, n);
      repeat (6) @(negedge clk);
      for (int i = 0; i < 3; i++) check_vec("zseed_sig0", seen0_q, i, basic[i]);
      check("zseed_nvalid", 64'(valid_edges.size()), 64'd3);

      // zero count
      clear_logs();
      do_start(32'h1, 0, 0, n);
      repeat (4) @(negedge clk);
      check("zcnt_nvalid", 64'(valid_edges.size()), 64'd0);
      check_edge("zcnt_done_edge", done_edges, 0, n + 1);
      check("zcnt_sent", 64'(sent), 64'd0);

      // stall on edges N+2 and N+3
      clear_logs();
      do_start(32'h1, 4, 0, n);
      @(negedge clk);
      hold = 1'b1;
      repeat (2) @(negedge clk);
      hold = 1'b0;
      repeat (6) @(negedge clk);
      check_edge("stall_v0", valid_edges, 0, n + 1);
      check_edge("stall_v1", valid_edges, 1, n + 4);
      check_edge("stall_v2", valid_edges, 2, n + 5);
      check_edge("stall_v3", valid_edges, 3, n + 6);
      for (int i = 0; i < 4; i++) check_vec("stall_sig0", seen0_q, i, basic[i]);
      check_edge("stall_done_edge", done_edges, 0, n + 7);

      // injection on vector 3
      clear_logs();
      do_start(32'h1, 4, 3, n);
      repeat (8) @(negedge clk);
      check_vec("inj_sig0_3", seen0_q, 2, 8'h02);
`ifdef ARR_STIM_INJECT_EN
      check_vec("inj_sig1_3", seen1_q, 2, 8'h03);
`else
      check_vec("inj_sig1_3", seen1_q, 2, 8'h02);
`endif
      check_vec("inj_sig1_4", seen1_q, 3, 8'h01);

      // asynchronous reset mid-run, then restart
      clear_logs();
      do_start(32'h1, 4, 0, n);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", 64'(valid), 64'h0);
      check("arst_busy", 64'(busy), 64'h0);
      check("arst_sent", 64'(sent), 64'h0);
      check("arst_sig0", 64'(sig0), 64'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("arst_no_done", 64'(done_edges.size()), 64'd0);
      clear_logs();
      do_start(32'h1, 2, 0, n);
      repeat (5) @(negedge clk);
      check_vec("arst_restart0", seen0_q, 0, 8'h01);
      check_vec("arst_restart1", seen0_q, 1, 8'h03);

      // start pulse while busy is ignored
      clear_logs();
      do_start(32'h1, 4, 0, n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("busy_start_ndone", 64'(done_edges.size()), 64'd1);
      check("busy_start_nvalid", 64'(valid_edges.size()), 64'd4);
      check("busy_start_sent", 64'(sent), 64'd4);

      // start held high: new sequence on the first IDLE edge after done
      clear_logs();
      @(negedge clk);
      seed = 32'h1; count = CNT_W'(2); inject = '0; start = 1'b1;
      @(negedge clk);
      n = edge_cnt;
      repeat (4) @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      check_edge("held_v2", valid_edges, 2, n + 5);
      check_edge("held_done0", done_edges, 0, n + 3);
      check_edge("held_done1", done_edges, 1, n + 7);
      check("held_nvalid", 64'(valid_edges.size()), 64'd4);

      // maximum count with periodic stalls
      clear_logs();
      do_start(32'hdead_beef, 255, 200, n);
      for (int i = 0; i < 800 && done_edges.size() == 0; i++) begin
         hold = (i % 3 == 0);
         @(negedge clk);
      end
      hold = 1'b0;
      repeat (2) @(negedge clk);
      check("max_ndone", 64'(done_edges.size()), 64'd1);
      check("max_nvalid", 64'(valid_edges.size()), 64'd255);
      check("max_sent", 64'(sent), 64'd255);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
